// File: rtl/master_port.sv
// Serial bus master port: takes a parallel user request, wins the bus from the
// arbiter, shifts the address (and write data) out LSB first, and assembles
// serially returned read data. Supports a slave-initiated split of a read.
module master_port #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_dvalid,
  input  logic [ADDR_WIDTH-1:0] i_daddr,
  input  logic [DATA_WIDTH-1:0] i_dwdata,
  input  logic                  i_dmode,
  output logic                  o_dready,
  output logic [DATA_WIDTH-1:0] o_drdata,
  output logic                  o_drvalid,
  output logic                  o_mbreq,
  input  logic                  i_mbgrant,
  output logic                  o_mwdata,
  output logic                  o_mmode,
  output logic                  o_mwvalid,
  input  logic                  i_mrdata,
  input  logic                  i_mrvalid,
  input  logic                  i_sready,
  input  logic                  i_ssplit
);

  localparam int unsigned MaxWidth = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CntWidth = $clog2(MaxWidth + 1);
  localparam logic [CntWidth-1:0] AddrLast = CntWidth'(ADDR_WIDTH - 1);
  localparam logic [CntWidth-1:0] DataLast = CntWidth'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StWdata,
    StRwait,
    StRdata,
    StSplit,
    StDone
  } state_e;

  state_e                r_state;
  state_e                w_state_d;
  logic [CntWidth-1:0]   r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rbuf;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_mode;

  logic w_cnt_inc;
  logic w_shift_addr;
  logic w_shift_wdata;
  logic w_rx_bit;
  logic w_rx_last;
  logic w_cnt_keep;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state decode, datapath strobes and state-derived outputs.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_inc     = 1'b0;
    w_shift_addr  = 1'b0;
    w_shift_wdata = 1'b0;
    w_rx_bit      = 1'b0;
    w_rx_last     = 1'b0;
    o_dready      = 1'b0;
    o_drvalid     = 1'b0;
    o_mbreq       = 1'b0;
    o_mwvalid     = 1'b0;
    o_mwdata      = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_dready = 1'b1;
        if (i_dvalid) w_state_d = StReq;
      end
      StReq: begin
        o_mbreq = 1'b1;
        if (i_mbgrant && i_sready) w_state_d = StAddr;
      end
      StAddr: begin
        o_mbreq   = 1'b1;
        o_mwvalid = 1'b1;
        o_mwdata  = r_addr[0];
        if (!i_mbgrant) begin
          // Lost the bus mid-transfer: the request is dropped.
          w_state_d = StIdle;
        end else begin
          w_shift_addr = 1'b1;
          w_cnt_inc    = 1'b1;
          if (r_cnt == AddrLast) w_state_d = r_mode ? StWdata : StRwait;
        end
      end
      StWdata: begin
        o_mbreq   = 1'b1;
        o_mwvalid = 1'b1;
        o_mwdata  = r_wdata[0];
        if (!i_mbgrant) begin
          w_state_d = StIdle;
        end else begin
          w_shift_wdata = 1'b1;
          w_cnt_inc     = 1'b1;
          if (r_cnt == DataLast) w_state_d = StDone;
        end
      end
      StRwait: begin
        o_mbreq = 1'b1;
        if (i_ssplit) begin
          w_state_d = StSplit;
        end else if (i_mrvalid) begin
          w_rx_bit  = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_cnt == DataLast) begin
            w_rx_last = 1'b1;
            w_state_d = StDone;
          end
        end
      end
      StRdata: begin
        o_mbreq = 1'b1;
        if (i_mrvalid) begin
          w_rx_bit  = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_cnt == DataLast) begin
            w_rx_last = 1'b1;
            w_state_d = StDone;
          end
        end
      end
      StSplit: begin
        if (i_mbgrant) w_state_d = StRdata;
      end
      StDone: begin
        o_drvalid = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // A split keeps the partial read count across SPLIT and back into RDATA.
  assign w_cnt_keep = (w_state_d == StSplit) || (r_state == StSplit);

  assign o_mmode  = r_mode;
  assign o_drdata = r_rdata;

  // Request capture, shift registers, read assembly and bit counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_rdata <= '0;
      r_mode  <= 1'b0;
    end else begin
      if (r_state == StIdle && i_dvalid) begin
        r_addr  <= i_daddr;
        r_wdata <= i_dwdata;
        r_mode  <= i_dmode;
      end
      if (w_shift_addr) r_addr <= r_addr >> 1;
      if (w_shift_wdata) r_wdata <= r_wdata >> 1;
      // Shifting in from the top lands received bit n at position n once all
      // DATA_WIDTH bits have arrived.
      if (w_rx_bit) r_rbuf <= {i_mrdata, r_rbuf[DATA_WIDTH-1:1]};
      if (w_rx_last) r_rdata <= {i_mrdata, r_rbuf[DATA_WIDTH-1:1]};
      if ((w_state_d != r_state) && !w_cnt_keep) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: reset, write, read, split read, slave not
// ready, grant loss and mid-transfer reset.
module tb_master_port;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          dvalid;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dmode;
  logic          dready;
  logic [DW-1:0] drdata;
  logic          drvalid;
  logic          mbreq;
  logic          mbgrant;
  logic          mwdata;
  logic          mmode;
  logic          mwvalid;
  logic          mrdata;
  logic          mrvalid;
  logic          sready;
  logic          ssplit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  master_port #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_dvalid (dvalid),
    .i_daddr  (daddr),
    .i_dwdata (dwdata),
    .i_dmode  (dmode),
    .o_dready (dready),
    .o_drdata (drdata),
    .o_drvalid(drvalid),
    .o_mbreq  (mbreq),
    .i_mbgrant(mbgrant),
    .o_mwdata (mwdata),
    .o_mmode  (mmode),
    .o_mwvalid(mwvalid),
    .i_mrdata (mrdata),
    .i_mrvalid(mrvalid),
    .i_sready (sready),
    .i_ssplit (ssplit)
  );

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL reset_dready got %b want 1", dready); end
    checks++; if (mbreq !== 1'b0) begin errors++; $display("FAIL reset_mbreq got %b want 0", mbreq); end
    checks++; if (mwvalid !== 1'b0) begin errors++; $display("FAIL reset_mwvalid got %b want 0", mwvalid); end
    checks++; if (mwdata !== 1'b0) begin errors++; $display("FAIL reset_mwdata got %b want 0", mwdata); end
    checks++; if (mmode !== 1'b0) begin errors++; $display("FAIL reset_mmode got %b want 0", mmode); end
    checks++; if (drvalid !== 1'b0) begin errors++; $display("FAIL reset_drvalid got %b want 0", drvalid); end
    checks++; if (drdata !== 8'h00) begin errors++; $display("FAIL reset_drdata got %h want 00", drdata); end
    step();
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL idle_dready got %b want 1", dready); end
  endtask

  // One write: gw cycles of grant low in REQ, then sw cycles granted but not ready.
  task automatic run_write(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int gw, input int sw);
    logic [AW+DW-1:0] cap;
    logic [AW+DW-1:0] exp_bits;
    int nb, pulses, dv_cyc, bad_req, exp_cyc, k;
    cap = '0; nb = 0; pulses = 0; dv_cyc = -1; bad_req = 0;
    exp_bits = {d, a};
    exp_cyc = 1 + gw + sw + AW + DW + 1;
    daddr = a; dwdata = d; dmode = 1'b1; dvalid = 1'b1; mbgrant = 1'b0; sready = 1'b0;
    for (int c = 1; c <= exp_cyc + 3; c++) begin
      step();
      if (c == 1) begin
        dvalid = 1'b0;
        checks++; if (mmode !== 1'b1) begin errors++; $display("FAIL %s_mmode got %b want 1", name, mmode); end
      end
      if (c <= 1 + gw + sw) begin
        if (mbreq !== 1'b1 || mwvalid !== 1'b0 || dready !== 1'b0) bad_req++;
      end
      if (mwvalid === 1'b1) begin
        if (nb < AW + DW) cap[nb] = mwdata;
        nb++;
      end
      if (drvalid === 1'b1) begin
        pulses++;
        dv_cyc = c;
      end
      k = c - 1;
      mbgrant = (k >= gw);
      sready = (k >= gw + sw);
    end
    checks++; if (dv_cyc != exp_cyc) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, dv_cyc, exp_cyc); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL %s_pulses got %0d want 1", name, pulses); end
    checks++; if (nb != AW + DW) begin errors++; $display("FAIL %s_nbits got %0d want %0d", name, nb, AW + DW); end
    checks++; if (cap !== exp_bits) begin errors++; $display("FAIL %s_serial got %h want %h", name, cap, exp_bits); end
    checks++; if (bad_req != 0) begin errors++; $display("FAIL %s_req_hold got %0d bad cycles want 0", name, bad_req); end
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL %s_end_dready got %b want 1", name, dready); end
    mbgrant = 1'b0; sready = 1'b0;
  endtask

  // One read; with split the slave splits after 3 bits and regrants 10 cycles later.
  task automatic run_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit split);
    logic [AW-1:0] cap;
    logic [DW-1:0] rd;
    int nb, pulses, dv_cyc, rx, bad_split, exp_cyc, e;
    cap = '0; rd = '0; nb = 0; pulses = 0; dv_cyc = -1; rx = 0; bad_split = 0;
    exp_cyc = split ? 33 : 23;
    daddr = a; dwdata = 8'hFF; dmode = 1'b0; dvalid = 1'b1;
    mbgrant = 1'b1; sready = 1'b1; mrvalid = 1'b0; mrdata = 1'b0; ssplit = 1'b0;
    for (int c = 1; c <= exp_cyc + 3; c++) begin
      step();
      if (c == 1) begin
        dvalid = 1'b0;
        checks++; if (mmode !== 1'b0) begin errors++; $display("FAIL %s_mmode got %b want 0", name, mmode); end
      end
      if (mwvalid === 1'b1) begin
        if (nb < AW) cap[nb] = mwdata;
        nb++;
      end
      if (drvalid === 1'b1) begin
        pulses++;
        dv_cyc = c;
        rd = drdata;
      end
      if (split && c >= 18 && c <= 27) begin
        if (mbreq !== 1'b0 || dready !== 1'b0) bad_split++;
      end
      // Inputs for the next edge.
      e = c + 1;
      mrvalid = 1'b0; mrdata = 1'b0; ssplit = 1'b0; mbgrant = 1'b1;
      if (e >= 5 && e <= 7) begin
        mrvalid = 1'b1; mrdata = 1'b1;
      end
      if (!split) begin
        if (e >= 15 && e != 17 && rx < DW) begin
          mrvalid = 1'b1; mrdata = d[rx]; rx++;
        end
      end else begin
        if ((e >= 15 && e <= 17) || (e >= 29 && rx < DW)) begin
          mrvalid = 1'b1; mrdata = d[rx]; rx++;
        end
        if (e == 18) ssplit = 1'b1;
        if (e >= 18 && e <= 27) mbgrant = 1'b0;
        if (e >= 20 && e <= 22) begin
          mrvalid = 1'b1; mrdata = e[0];
        end
      end
    end
    checks++; if (dv_cyc != exp_cyc) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, dv_cyc, exp_cyc); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL %s_pulses got %0d want 1", name, pulses); end
    checks++; if (rd !== d) begin errors++; $display("FAIL %s_rdata got %h want %h", name, rd, d); end
    checks++; if (drdata !== d) begin errors++; $display("FAIL %s_drdata_hold got %h want %h", name, drdata, d); end
    checks++; if (nb != AW) begin errors++; $display("FAIL %s_addr_bits got %0d want %0d", name, nb, AW); end
    checks++; if (cap !== a) begin errors++; $display("FAIL %s_addr got %h want %h", name, cap, a); end
    if (split) begin
      checks++; if (bad_split != 0) begin errors++; $display("FAIL %s_split_mbreq got %0d bad cycles want 0", name, bad_split); end
    end
    mbgrant = 1'b0; sready = 1'b0; mrvalid = 1'b0; ssplit = 1'b0;
  endtask

  task automatic test_write();
    run_write("write", 12'h5A3, 8'hC6, 0, 0);
    run_write("write_gw2", 12'h5A3, 8'hC6, 2, 0);
  endtask

  task automatic test_read();
    run_read("read", 12'h010, 8'hA5, 1'b0);
  endtask

  task automatic test_split();
    run_read("split", 12'h7E1, 8'h3C, 1'b1);
  endtask

  task automatic test_sready();
    run_write("sready", 12'h0F0, 8'h5A, 0, 5);
  endtask

  task automatic test_grant_drop();
    int nb, pulses;
    nb = 0; pulses = 0;
    daddr = 12'hABC; dwdata = 8'h81; dmode = 1'b1; dvalid = 1'b1; mbgrant = 1'b1; sready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 1) dvalid = 1'b0;
      if (mwvalid === 1'b1) nb++;
      if (drvalid === 1'b1) pulses++;
      if (c == 8) begin
        checks++; if (dready !== 1'b1) begin errors++; $display("FAIL gdrop_dready got %b want 1", dready); end
        checks++; if (mbreq !== 1'b0) begin errors++; $display("FAIL gdrop_mbreq got %b want 0", mbreq); end
        checks++; if (mwvalid !== 1'b0) begin errors++; $display("FAIL gdrop_mwvalid got %b want 0", mwvalid); end
      end
      // ADDR bit 5 is on the wire at c=7; grant is low for the next edge only.
      mbgrant = (c != 7);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL gdrop_pulses got %0d want 0", pulses); end
    checks++; if (nb != 6) begin errors++; $display("FAIL gdrop_bits got %0d want 6", nb); end
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL gdrop_end_dready got %b want 1", dready); end
    mbgrant = 1'b0; sready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    daddr = 12'h123; dwdata = 8'hFF; dmode = 1'b1; dvalid = 1'b1; mbgrant = 1'b1; sready = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 1) dvalid = 1'b0;
      if (drvalid === 1'b1) pulses++;
    end
    // WDATA bit 3 is on the wire now.
    checks++; if (mwvalid !== 1'b1 || mwdata !== 1'b1) begin errors++; $display("FAIL rmid_wdata3 got %b%b want 11", mwvalid, mwdata); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (dready !== 1'b1) begin errors++; $display("FAIL rmid_dready got %b want 1", dready); end
    checks++; if (mbreq !== 1'b0) begin errors++; $display("FAIL rmid_mbreq got %b want 0", mbreq); end
    checks++; if (mwvalid !== 1'b0 || mwdata !== 1'b0) begin errors++; $display("FAIL rmid_mw got %b%b want 00", mwvalid, mwdata); end
    checks++; if (mmode !== 1'b0) begin errors++; $display("FAIL rmid_mmode got %b want 0", mmode); end
    checks++; if (drdata !== 8'h00) begin errors++; $display("FAIL rmid_drdata got %h want 00", drdata); end
    for (int c = 0; c < 10; c++) begin
      if (drvalid === 1'b1) pulses++;
      step();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_pulses got %0d want 0", pulses); end
    mbgrant = 1'b0; sready = 1'b0;
    run_write("after_rst", 12'h6B2, 8'h39, 0, 0);
  endtask

  initial begin
    rst = 1'b1; dvalid = 1'b0; daddr = '0; dwdata = '0; dmode = 1'b0;
    mbgrant = 1'b0; mrdata = 1'b0; mrvalid = 1'b0; sready = 1'b0; ssplit = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_split();
    test_sready();
    test_grant_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
